// File: rtl/dcpu_timer.sv
// dcpu_timer: memory-mapped prescaled 16-bit down-counter with interrupt.
//
// Ports:
//   i_clk    - clock
//   i_reset  - asynchronous, active-high reset
//   i_addr   - byte address from the CPU (valid every cycle, no strobe)
//   i_dat    - write data from the CPU
//   i_rw     - 1 = read, 0 = write
//   o_dat    - combinational read data, 0 when not selected (OR-muxable)
//   o_sel    - address falls inside the 16-byte register window
//   o_int    - level interrupt request = EXPIRED & IRQEN
//
// Register index = i_addr[3:1]:
//   0 CTRL     {IRQEN, AUTO, EN}
//   1 STATUS   {RUNNING, EXPIRED}, EXPIRED is write-1-to-clear
//   2 PRESCALE
//   3 RELOAD
//   4 COUNT    live counter, write loads it
//   5..7       read 0, writes ignored
module dcpu_timer #(
  parameter logic [15:0] BASE_ADDR      = 16'hFF00,
  parameter logic [15:0] RESET_PRESCALE = 16'h0000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [15:0] i_addr,
  input  logic [15:0] i_dat,
  input  logic        i_rw,
  output logic [15:0] o_dat,
  output logic        o_sel,
  output logic        o_int
);

  localparam logic [2:0] IDX_CTRL     = 3'd0;
  localparam logic [2:0] IDX_STATUS   = 3'd1;
  localparam logic [2:0] IDX_PRESCALE = 3'd2;
  localparam logic [2:0] IDX_RELOAD   = 3'd3;
  localparam logic [2:0] IDX_COUNT    = 3'd4;

  logic        en_q, en_d;
  logic        auto_q, auto_d;
  logic        irqen_q, irqen_d;
  logic        expired_q, expired_d;
  logic [15:0] prescale_q, prescale_d;
  logic [15:0] reload_q, reload_d;
  logic [15:0] count_q, count_d;
  logic [15:0] pcnt_q, pcnt_d;

  logic [2:0]  idx;
  logic        wr;
  logic        tick;
  logic        expire;

  assign o_sel = (i_addr[15:4] == BASE_ADDR[15:4]);
  assign idx   = i_addr[3:1];
  assign wr    = o_sel && !i_rw;
  assign tick  = en_q && (pcnt_q == 16'd0);
  assign expire = tick && (count_q == 16'd0);

  // Both inputs are flops, so the interrupt line cannot glitch.
  assign o_int = expired_q & irqen_q;

  always_comb begin
    en_d       = en_q;
    auto_d     = auto_q;
    irqen_d    = irqen_q;
    expired_d  = expired_q;
    prescale_d = prescale_q;
    reload_d   = reload_q;
    count_d    = count_q;
    pcnt_d     = pcnt_q;

    if (en_q) begin
      pcnt_d = tick ? prescale_q : (pcnt_q - 16'd1);
    end

    if (tick) begin
      if (count_q != 16'd0) begin
        count_d = count_q - 16'd1;
      end else if (auto_q) begin
        count_d = reload_q;
      end else begin
        en_d = 1'b0;
      end
    end

    // Bus writes are applied after the timer events so a written value
    // wins over the counter's own update in the same cycle.
    if (wr) begin
      case (idx)
        IDX_CTRL: begin
          en_d    = i_dat[0];
          auto_d  = i_dat[1];
          irqen_d = i_dat[2];
          // Only a fresh enable restarts the prescaler; re-writing EN=1
          // while running leaves the current prescale phase alone.
          if (!en_q && i_dat[0]) begin
            pcnt_d = prescale_q;
          end
        end
        IDX_STATUS: begin
          if (i_dat[0]) begin
            expired_d = 1'b0;
          end
        end
        IDX_PRESCALE: prescale_d = i_dat;
        IDX_RELOAD:   reload_d   = i_dat;
        IDX_COUNT:    count_d    = i_dat;
        default: ;
      endcase
    end

    // Setting EXPIRED overrides a simultaneous clear so no event is lost.
    if (expire) begin
      expired_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      en_q       <= 1'b0;
      auto_q     <= 1'b0;
      irqen_q    <= 1'b0;
      expired_q  <= 1'b0;
      prescale_q <= RESET_PRESCALE;
      reload_q   <= 16'd0;
      count_q    <= 16'd0;
      pcnt_q     <= RESET_PRESCALE;
    end else begin
      en_q       <= en_d;
      auto_q     <= auto_d;
      irqen_q    <= irqen_d;
      expired_q  <= expired_d;
      prescale_q <= prescale_d;
      reload_q   <= reload_d;
      count_q    <= count_d;
      pcnt_q     <= pcnt_d;
    end
  end

  always_comb begin
    o_dat = 16'd0;
    if (o_sel && i_rw) begin
      case (idx)
        IDX_CTRL:     o_dat = {13'd0, irqen_q, auto_q, en_q};
        IDX_STATUS:   o_dat = {14'd0, en_q, expired_q};
        IDX_PRESCALE: o_dat = prescale_q;
        IDX_RELOAD:   o_dat = reload_q;
        IDX_COUNT:    o_dat = count_q;
        default:      o_dat = 16'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_dcpu_timer.sv
module tb_dcpu_timer;

  localparam logic [15:0] BASE = 16'hFF00;
  localparam logic [15:0] RPRE = 16'h0000;

  logic        i_clk;
  logic        i_reset;
  logic [15:0] i_addr;
  logic [15:0] i_dat;
  logic        i_rw;
  logic [15:0] o_dat;
  logic        o_sel;
  logic        o_int;

  int checks = 0;
  int errors = 0;

  logic [15:0] obs_dat;
  logic        obs_int;

  // Reference state: register contents as software would see them, plus
  // the prescaler phase.
  int m_en, m_auto, m_irqen, m_exp;
  int m_pre, m_rel, m_cnt, m_pcnt;

  dcpu_timer #(.BASE_ADDR(BASE), .RESET_PRESCALE(RPRE)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_addr(i_addr), .i_dat(i_dat),
    .i_rw(i_rw), .o_dat(o_dat), .o_sel(o_sel), .o_int(o_int)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_en = 0; m_auto = 0; m_irqen = 0; m_exp = 0;
    m_pre = int'(RPRE); m_rel = 0; m_cnt = 0; m_pcnt = int'(RPRE);
  endtask

  function automatic logic [15:0] mread(input int idx);
    case (idx)
      0: return 16'(m_en + 2 * m_auto + 4 * m_irqen);
      1: return 16'(m_exp + 2 * m_en);
      2: return 16'(m_pre);
      3: return 16'(m_rel);
      4: return 16'(m_cnt);
      default: return 16'd0;
    endcase
  endfunction

  // One clock of the timer as described by its rules: prescaler tick,
  // counter reaction to the tick, then the bus write (which wins), then
  // expiry setting EXPIRED regardless of a clear.
  task automatic model_step(input logic [15:0] addr, input logic [15:0] dat, input logic rw);
    int n_en, n_auto, n_irqen, n_exp, n_pre, n_rel, n_cnt, n_pcnt;
    bit is_tick, is_exp, is_wr;
    int idx;
    n_en = m_en; n_auto = m_auto; n_irqen = m_irqen; n_exp = m_exp;
    n_pre = m_pre; n_rel = m_rel; n_cnt = m_cnt; n_pcnt = m_pcnt;
    is_tick = (m_en == 1) && (m_pcnt == 0);
    is_exp  = is_tick && (m_cnt == 0);
    is_wr   = (addr[15:4] == BASE[15:4]) && !rw;
    idx     = int'(addr[3:1]);
    if (m_en == 1) n_pcnt = is_tick ? m_pre : m_pcnt - 1;
    if (is_tick) begin
      if (m_cnt > 0) n_cnt = m_cnt - 1;
      else if (m_auto == 1) n_cnt = m_rel;
      else n_en = 0;
    end
    if (is_wr) begin
      if (idx == 0) begin
        n_en = int'(dat[0]); n_auto = int'(dat[1]); n_irqen = int'(dat[2]);
        if (m_en == 0 && dat[0]) n_pcnt = m_pre;
      end else if (idx == 1) begin
        if (dat[0]) n_exp = 0;
      end else if (idx == 2) n_pre = int'(dat);
      else if (idx == 3) n_rel = int'(dat);
      else if (idx == 4) n_cnt = int'(dat);
    end
    if (is_exp) n_exp = 1;
    m_en = n_en; m_auto = n_auto; m_irqen = n_irqen; m_exp = n_exp;
    m_pre = n_pre; m_rel = n_rel; m_cnt = n_cnt; m_pcnt = n_pcnt;
  endtask

  // Called just after a falling edge: drive the bus, compare the
  // combinational outputs against the model, take the rising edge, step
  // the model, and return at the next falling edge.
  task automatic cycle(input logic [15:0] addr, input logic [15:0] dat, input logic rw);
    logic exp_sel;
    logic [15:0] exp_dat;
    i_addr = addr; i_dat = dat; i_rw = rw;
    #1;
    exp_sel = (addr[15:4] == BASE[15:4]);
    exp_dat = (exp_sel && rw) ? mread(int'(addr[3:1])) : 16'd0;
    obs_dat = o_dat;
    obs_int = o_int;
    check("sel", {15'd0, o_sel}, {15'd0, exp_sel});
    check("dat", o_dat, exp_dat);
    check("int", {15'd0, o_int}, 16'(m_exp * m_irqen));
    @(posedge i_clk);
    model_step(addr, dat, rw);
    @(negedge i_clk);
  endtask

  task automatic wr(input int idx, input logic [15:0] val);
    cycle(BASE + 16'(idx * 2), val, 1'b0);
  endtask

  task automatic rd(input int idx);
    cycle(BASE + 16'(idx * 2), 16'd0, 1'b1);
  endtask

  initial begin
    logic [15:0] a, d;
    logic rw;
    int r;

    i_reset = 1'b1; i_addr = BASE + 16'd2; i_dat = 16'd0; i_rw = 1'b1;
    model_reset();
    #1;
    check("rst_status", o_dat, 16'h0000);
    check("rst_int", {15'd0, o_int}, 16'd0);
    @(negedge i_clk);
    i_reset = 1'b0;

    // reset values
    rd(0); check("rst_ctrl", obs_dat, 16'h0000);
    rd(2); check("rst_pre", obs_dat, RPRE);
    rd(4); check("rst_cnt", obs_dat, 16'h0000);

    // register access
    wr(0, 16'hFFFF);
    rd(0); check("ctrl_mask", obs_dat, 16'h0007);
    cycle(BASE + 16'd1, 16'd0, 1'b1); check("odd_addr", obs_dat, 16'h0007);
    rd(6); check("idx6", obs_dat, 16'h0000);
    cycle(BASE + 16'd16, 16'd0, 1'b1);
    check("out_win_dat", obs_dat, 16'h0000);
    wr(0, 16'h0000);
    wr(1, 16'h0001);
    rd(1); check("quiet_clr", obs_dat, 16'h0000);

    // one-shot: expiry exactly 3 clocks after the enabling write
    wr(2, 16'd0);
    wr(4, 16'd2);
    wr(0, 16'h0005);
    rd(1); check("os_e1", obs_dat, 16'h0002);
    rd(1); check("os_e2", obs_dat, 16'h0002);
    rd(1); check("os_e3", obs_dat, 16'h0002);
    rd(1); check("os_expired", obs_dat, 16'h0001);
    check("os_int", {15'd0, obs_int}, 16'd1);
    rd(4); check("os_cnt0", obs_dat, 16'h0000);
    rd(4); check("os_cnt_hold", obs_dat, 16'h0000);

    // auto-reload with prescale
    wr(0, 16'h0000);
    wr(1, 16'h0001);
    wr(2, 16'd3);
    wr(3, 16'd4);
    wr(4, 16'd4);
    wr(0, 16'h0003);
    for (int k = 0; k <= 20; k++) begin
      rd(4);
      check("auto_cnt", obs_dat, (k < 20) ? 16'(4 - k / 4) : 16'd4);
    end
    rd(1); check("auto_exp", obs_dat, 16'h0003);
    wr(1, 16'h0001);
    rd(1); check("auto_clr", obs_dat, 16'h0002);
    for (int k = 24; k <= 38; k++) rd(4);
    wr(1, 16'h0001);                       // collides with the expiry edge
    rd(1); check("w1c_collide", obs_dat, 16'h0003);

    // IRQ masking
    check("mask_int", {15'd0, obs_int}, 16'd0);
    wr(0, 16'h0007);
    rd(1); check("unmask_int", {15'd0, obs_int}, 16'd1);

    // asynchronous reset between clock edges
    i_addr = BASE + 16'd8; i_rw = 1'b1;
    #2 i_reset = 1'b1;
    #1;
    check("arst_int", {15'd0, o_int}, 16'd0);
    check("arst_cnt", o_dat, 16'h0000);
    i_addr = BASE;
    #1;
    check("arst_ctrl", o_dat, 16'h0000);
    model_reset();
    @(posedge i_clk);
    @(negedge i_clk);
    i_reset = 1'b0;
    wr(4, 16'd3);
    for (int k = 0; k < 4; k++) begin
      rd(4); check("arst_idle", obs_dat, 16'd3);
    end

    // randomized traffic against the reference model
    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 9);
      if (r == 0) a = 16'($urandom);
      else a = BASE + 16'($urandom_range(0, 15));
      rw = ($urandom_range(0, 3) != 0);
      case (int'(a[3:1]))
        0: d = 16'($urandom_range(0, 7));
        1: d = 16'($urandom_range(0, 3));
        2, 3, 4: d = 16'($urandom_range(0, 6));
        default: d = 16'($urandom);
      endcase
      cycle(a, d, rw);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
